// File: rtl/mult_pingpong_buffer.sv
// Multiplier feeding a two-bank ping-pong buffer with block drain; MULT_SIGNED_EN selects signed arithmetic.
// Latency: result write PIPE cycles after acceptance; drained word valid one cycle after its read strobe.
// Backpressure: RDY_mult drops when free bank space cannot cover in-flight results; dropped requests set ERR_drop.
module mult_pingpong_buffer #(
    parameter int OPW  = 16,
    parameter int N    = 32,
    parameter int AW   = 6,
    parameter int PIPE = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN_mult,
    input  logic [OPW-1:0]  mult_input0,
    input  logic [OPW-1:0]  mult_input1,
    output logic            RDY_mult,
    output logic            EN_writeMem,
    output logic [AW:0]     writeMem_addr,
    output logic [N-1:0]    writeMem_val,
    input  logic            EN_blockRead,
    output logic            EN_readMem,
    output logic [AW:0]     readMem_addr,
    input  logic [N-1:0]    readMem_val,
    output logic            VALID_memVal,
    output logic [N-1:0]    memVal_data,
    output logic [1:0]      BANK_full,
    output logic            ERR_drop
);

    localparam int DEPTH = 1 << AW;
    localparam int PW    = 2 * OPW;
    localparam int CW    = AW + 2;

    typedef enum logic {R_IDLE = 1'b0, R_READ = 1'b1} rd_state_t;

    logic [PW-1:0] op0_ext, op1_ext, prod;
    logic [N-1:0]  result;

    // Sign-extending to full product width makes the low PW bits correct for both signednesses.
`ifdef MULT_SIGNED_EN
    assign op0_ext = {{OPW{mult_input0[OPW-1]}}, mult_input0};
    assign op1_ext = {{OPW{mult_input1[OPW-1]}}, mult_input1};
`else
    assign op0_ext = {{OPW{1'b0}}, mult_input0};
    assign op1_ext = {{OPW{1'b0}}, mult_input1};
`endif
    assign prod = op0_ext * op1_ext;

    generate
        if (N > PW) begin : g_ext
`ifdef MULT_SIGNED_EN
            assign result = {{(N-PW){prod[PW-1]}}, prod};
`else
            assign result = {{(N-PW){1'b0}}, prod};
`endif
        end else begin : g_trunc
            assign result = prod[N-1:0];
        end
    endgenerate

    logic [PIPE-1:0] pvld_q, pvld_d;
    logic [N-1:0]    pdat_q [PIPE];
    logic [N-1:0]    pdat_d [PIPE];
    logic [AW-1:0]   wa_q, wa_d, ra_q, ra_d;
    logic            wb_q, wb_d, rb_q, rb_d;
    logic [1:0]      full_q, full_d;
    logic            err_q, err_d;
    logic            rvld_q, rvld_d;
    rd_state_t       state_q, state_d;

    logic            accept, rdy, wr_en, rd_en, rd_other;
    logic [1:0]      set_full, clr_full;
    logic [CW-1:0]   credit, inflight;

    assign wr_en    = pvld_q[PIPE-1];
    assign rd_other = (state_q == R_READ) && (rb_q != wb_q);
    assign accept   = EN_mult && rdy;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE; i++) begin
            inflight = inflight + CW'(pvld_q[i]);
        end
    end

    // The current bank offers its remaining words; the other bank only when it is empty and idle.
    always_comb begin
        credit = (full_q[wb_q] ? '0 : (CW'(DEPTH) - CW'(wa_q)))
               + ((full_q[~wb_q] || rd_other) ? '0 : CW'(DEPTH));
        rdy    = credit > inflight;
    end

    // Each stage only captures on a valid input, so the last stage holds the last written value.
    always_comb begin
        pvld_d    = '0;
        pvld_d[0] = accept;
        for (int i = 0; i < PIPE; i++) begin
            pdat_d[i] = pdat_q[i];
        end
        if (accept) begin
            pdat_d[0] = result;
        end
        for (int i = 1; i < PIPE; i++) begin
            pvld_d[i] = pvld_q[i-1];
            if (pvld_q[i-1]) begin
                pdat_d[i] = pdat_q[i-1];
            end
        end
    end

    always_comb begin
        wb_d     = wb_q;
        wa_d     = wa_q;
        set_full = '0;
        if (wr_en) begin
            if (wa_q == {AW{1'b1}}) begin
                set_full[wb_q] = 1'b1;
                wb_d           = ~wb_q;
                wa_d           = '0;
            end else begin
                wa_d = wa_q + AW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rb_d     = rb_q;
        ra_d     = ra_q;
        clr_full = '0;
        rd_en    = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (EN_blockRead && full_q[rb_q]) begin
                    state_d = R_READ;
                end
            end
            R_READ: begin
                rd_en = 1'b1;
                if (ra_q == {AW{1'b1}}) begin
                    clr_full[rb_q] = 1'b1;
                    rb_d           = ~rb_q;
                    ra_d           = '0;
                    state_d        = R_IDLE;
                end else begin
                    ra_d = ra_q + AW'(1);
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // A fill and a drain completing on the same edge touch different banks, so both apply.
    always_comb begin
        full_d = (full_q | set_full) & ~clr_full;
        err_d  = err_q | (EN_mult & ~rdy);
        rvld_d = rd_en;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pvld_q  <= '0;
            for (int i = 0; i < PIPE; i++) begin
                pdat_q[i] <= '0;
            end
            wb_q    <= 1'b0;
            wa_q    <= '0;
            rb_q    <= 1'b0;
            ra_q    <= '0;
            full_q  <= '0;
            err_q   <= 1'b0;
            rvld_q  <= 1'b0;
            state_q <= R_IDLE;
        end else begin
            pvld_q  <= pvld_d;
            pdat_q  <= pdat_d;
            wb_q    <= wb_d;
            wa_q    <= wa_d;
            rb_q    <= rb_d;
            ra_q    <= ra_d;
            full_q  <= full_d;
            err_q   <= err_d;
            rvld_q  <= rvld_d;
            state_q <= state_d;
        end
    end

    assign RDY_mult      = rdy;
    assign EN_writeMem   = wr_en;
    assign writeMem_addr = {wb_q, wa_q};
    assign writeMem_val  = pdat_q[PIPE-1];
    assign EN_readMem    = rd_en;
    assign readMem_addr  = {rb_q, ra_q};
    assign VALID_memVal  = rvld_q;
    assign memVal_data   = readMem_val;
    assign BANK_full     = full_q;
    assign ERR_drop      = err_q;

endmodule

// File: tb/tb_mult_pingpong_buffer.sv
// Scoreboard bench for mult_pingpong_buffer: write values/addresses/latency, drain order, full/stall/drop flags.
module tb_mult_pingpong_buffer;

    localparam int OPW   = 16;
    localparam int N     = 32;
    localparam int AW    = 6;
    localparam int PIPE  = 2;
    localparam int DEPTH = 1 << AW;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            EN_mult = 1'b0;
    logic [OPW-1:0]  mult_input0 = '0;
    logic [OPW-1:0]  mult_input1 = '0;
    logic            EN_blockRead = 1'b0;
    logic [N-1:0]    readMem_val = '0;
    logic            RDY_mult, EN_writeMem, EN_readMem, VALID_memVal, ERR_drop;
    logic [AW:0]     writeMem_addr, readMem_addr;
    logic [N-1:0]    writeMem_val, memVal_data;
    logic [1:0]      BANK_full;

    mult_pingpong_buffer #(.OPW(OPW), .N(N), .AW(AW), .PIPE(PIPE)) dut (
        .CLK(CLK), .RST(RST), .EN_mult(EN_mult),
        .mult_input0(mult_input0), .mult_input1(mult_input1), .RDY_mult(RDY_mult),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
        .EN_blockRead(EN_blockRead), .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
        .readMem_val(readMem_val), .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
        .BANK_full(BANK_full), .ERR_drop(ERR_drop)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [N-1:0] val; int due; } wr_exp_t;
    wr_exp_t     wq[$];
    logic [N-1:0] mem [2*DEPTH];
    logic [AW:0] exp_waddr = '0;
    logic [AW:0] exp_raddr = '0;
    logic        rd_pend = 1'b0;
    logic [N-1:0] rd_exp = '0;
    int          rd_count = 0;
    logic        err_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [N-1:0] sa, sb;
        sa = N'($signed(a));
        sb = N'($signed(b));
        return sa * sb;
`else
        logic [N-1:0] ua, ub;
        ua = N'(a);
        ub = N'(b);
        return ua * ub;
`endif
    endfunction

    // Monitor: write scoreboard, memory model with one-cycle read latency, drain checks.
    always @(negedge CLK) begin : monitor
        wr_exp_t e;
        if (EN_writeMem) begin
            if (wq.size() == 0) begin
                chk("wr_spurious", 64'(EN_writeMem), 64'd0);
            end else begin
                e = wq.pop_front();
                chk("wr_val", 64'(writeMem_val), 64'(e.val));
                chk("wr_addr", 64'(writeMem_addr), 64'(exp_waddr));
                chk("wr_lat", 64'(cyc), 64'(e.due));
                mem[exp_waddr] = e.val;
                exp_waddr = exp_waddr + 1'b1;
            end
        end else if (wq.size() > 0 && wq[0].due <= cyc) begin
            chk("wr_missing", 64'(EN_writeMem), 64'd1);
            void'(wq.pop_front());
        end
        chk("rd_valid", 64'(VALID_memVal), 64'(rd_pend));
        if (rd_pend) chk("rd_data", 64'(memVal_data), 64'(rd_exp));
        rd_pend = EN_readMem && !RST;
        if (EN_readMem) begin
            chk("rd_addr", 64'(readMem_addr), 64'(exp_raddr));
            rd_exp = mem[exp_raddr];
            readMem_val = rd_exp;
            exp_raddr = exp_raddr + 1'b1;
            rd_count++;
        end
        if (RST) begin
            wq.delete();
            exp_waddr = '0;
            exp_raddr = '0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        EN_mult = 1'b0;
        EN_blockRead = 1'b0;
        err_exp = 1'b0;
        tick();
        @(negedge CLK);
        chk("rst_wr_en", 64'(EN_writeMem), 64'd0);
        chk("rst_rd_en", 64'(EN_readMem), 64'd0);
        chk("rst_valid", 64'(VALID_memVal), 64'd0);
        chk("rst_waddr", 64'(writeMem_addr), 64'd0);
        chk("rst_raddr", 64'(readMem_addr), 64'd0);
        chk("rst_full", 64'(BANK_full), 64'd0);
        chk("rst_err", 64'(ERR_drop), 64'd0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_rdy", 64'(RDY_mult), 64'd1);
        tick();
    endtask

    task automatic issue(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic [N-1:0] exp, output logic acc);
        EN_mult = 1'b1;
        mult_input0 = a;
        mult_input1 = b;
        @(negedge CLK);
        acc = RDY_mult;
        if (acc) wq.push_back('{exp, cyc + PIPE});
        else err_exp = 1'b1;
        tick();
        EN_mult = 1'b0;
    endtask

    task automatic wait_wr(input int lim);
        int n = 0;
        while (wq.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk("wr_drain_timeout", 64'(wq.size()), 64'd0);
        tick();
    endtask

    task automatic wait_reads(input int base, input int lim);
        int n = 0;
        while ((rd_count - base) < DEPTH && n < lim) begin
            tick();
            n++;
        end
        chk("drain_cnt", 64'(rd_count - base), 64'(DEPTH));
    endtask

    task automatic burst(input int cnt, input int pulse_at, input string tag);
        logic [OPW-1:0] a, b;
        logic acc;
        for (int k = 0; k < cnt; k++) begin
            a = OPW'($urandom);
            b = OPW'($urandom);
            if (k == pulse_at) EN_blockRead = 1'b1;
            issue(a, b, model(a, b), acc);
            EN_blockRead = 1'b0;
            chk(tag, 64'(acc), 64'd1);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic acc;
        logic [OPW-1:0] a, b;
        int base;

        do_reset();

        issue(16'd3, 16'd5, 32'd15, acc);
        chk("first_acc", 64'(acc), 64'd1);
        wait_wr(20);

`ifdef MULT_SIGNED_EN
        issue(16'hFFFE, 16'd3, 32'hFFFFFFFA, acc);
`else
        issue(16'hFFFE, 16'd3, 32'h0002FFFA, acc);
`endif
        chk("ext_acc", 64'(acc), 64'd1);
        issue(16'hFFFF, 16'hFFFF, model(16'hFFFF, 16'hFFFF), acc);
        issue(16'h8000, 16'h7FFF, model(16'h8000, 16'h7FFF), acc);
        issue(16'h0000, 16'h1234, model(16'h0000, 16'h1234), acc);
        for (int i = 0; i < 20; i++) begin
            a = OPW'($urandom);
            b = OPW'($urandom);
            issue(a, b, model(a, b), acc);
            chk("rand_acc", 64'(acc), 64'd1);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_wr(20);

        base = rd_count;
        EN_blockRead = 1'b1;
        tick();
        EN_blockRead = 1'b0;
        repeat (5) tick();
        chk("no_drain_empty", 64'(rd_count - base), 64'd0);

        do_reset();
        burst(DEPTH, -1, "b2b_rdy");
        wait_wr(20);
        chk("full_b0", 64'(BANK_full), 64'b01);
        burst(DEPTH, -1, "b1_rdy");
        wait_wr(20);
        chk("full_both", 64'(BANK_full), 64'b11);
        chk("rdy_full", 64'(RDY_mult), 64'd0);
        issue(16'd7, 16'd7, 32'd49, acc);
        chk("drop_acc", 64'(acc), 64'd0);
        repeat (PIPE + 3) tick();
        chk("err_drop", 64'(ERR_drop), 64'(err_exp));

        base = rd_count;
        EN_blockRead = 1'b1;
        tick();
        EN_blockRead = 1'b0;
        repeat (10) tick();
        chk("rdy_stall", 64'(RDY_mult), 64'd0);
        wait_reads(base, 200);
        repeat (3) tick();
        chk("full_after", 64'(BANK_full), 64'b10);
        chk("rdy_after", 64'(RDY_mult), 64'd1);
        issue(16'd9, 16'd11, 32'd99, acc);
        chk("reuse_acc", 64'(acc), 64'd1);
        wait_wr(20);

        do_reset();
        base = rd_count;
        burst(2 * DEPTH, DEPTH + 6, "pp_rdy");
        wait_wr(20);
        wait_reads(base, 200);
        repeat (3) tick();
        chk("pp_full", 64'(BANK_full), 64'b10);

        EN_blockRead = 1'b1;
        tick();
        EN_blockRead = 1'b0;
        repeat (10) tick();
        chk("mid_busy", 64'(EN_readMem), 64'd1);
        do_reset();
        base = rd_count;
        repeat (80) tick();
        chk("post_rst_reads", 64'(rd_count - base), 64'd0);
        chk("post_rst_full", 64'(BANK_full), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_pingpong_buffer.md
MULT_PINGPONG_BUFFER -- requirements
Module: mult_pingpong_buffer

Interface
REQ-001 The block SHALL have parameter OPW, default 16, meaning operand width in bits.
REQ-002 The block SHALL have parameter N, default 32, meaning result and memory word width.
REQ-003 The block SHALL have parameter AW, default 6, meaning per-bank address width, with DEPTH = 2**AW words per bank.
REQ-004 The block SHALL have parameter PIPE, default 2 (legal range 1..8), meaning multiply pipeline stages.
REQ-005 The block SHALL have these ports:
  CLK  input  1  sole clock; all state changes on rising edge
  RST  input  1  reset; synchronous, active-high
  EN_mult  input  1  request to multiply the current operands
  mult_input0, mult_input1  input  OPW  operands
  RDY_mult  output  1  multiply request will be accepted this cycle
  EN_writeMem  output  1  memory write strobe
  writeMem_addr  output  AW+1  {bank, word} write address
  writeMem_val  output  N  write data
  EN_blockRead  input  1  request to drain the oldest full bank
  EN_readMem  output  1  memory read strobe
  readMem_addr  output  AW+1  {bank, word} read address
  readMem_val  input  N  memory read data, one-cycle latency
  VALID_memVal  output  1  memVal_data is valid
  memVal_data  output  N  drained word, equal to readMem_val
  BANK_full  output  2  per-bank full flag
  ERR_drop  output  1  sticky flag: a request was dropped

Function
REQ-006 The result SHALL be mult_input0*mult_input1, resized to N bits: zero/sign-extended if N>2*OPW, LSBs kept if N<2*OPW.
REQ-007 A request SHALL be accepted iff EN_mult && RDY_mult; its result SHALL appear with EN_writeMem=1 exactly PIPE cycles after acceptance, one word per accepted request, in order.
REQ-008 EN_mult with RDY_mult=0 SHALL be ignored and SHALL set ERR_drop, which stays 1 until reset.
REQ-009 Write side SHALL hold bank pointer wb and word pointer wa; each write goes to {wb,wa}; wa increments; the write at wa=DEPTH-1 SHALL set BANK_full[wb], toggle wb and clear wa.
REQ-010 RDY_mult SHALL be 1 iff credit > inflight: credit = (DEPTH-wa if BANK_full[wb]=0, else 0) + (DEPTH if the other bank is neither full nor being read, else 0); inflight = accepted requests not yet written.
REQ-011 The block SHALL never write into a bank that is full or being read.
REQ-012 Read FSM SHALL have states R_IDLE and R_READ, plus read bank pointer rb (oldest full bank) and word pointer ra.
REQ-013 In R_IDLE with EN_blockRead=1 and BANK_full[rb]=1, the FSM SHALL enter R_READ on the next edge; EN_blockRead is ignored in R_READ or when no bank is full.
REQ-014 In R_READ, EN_readMem SHALL be 1 and readMem_addr={rb,ra} for DEPTH consecutive cycles, with ra running 0..DEPTH-1.
REQ-015 VALID_memVal SHALL be 1 exactly one cycle after each EN_readMem=1 cycle.
REQ-016 At the edge ending the ra=DEPTH-1 read cycle, the block SHALL clear BANK_full[rb], toggle rb, zero ra and return to R_IDLE.
REQ-017 A bank fill and the other bank's clear on the same edge SHALL both take effect.
REQ-018 When both banks are full, RDY_mult SHALL be 0 and writes SHALL stall until a drain completes.
REQ-019 writeMem_val SHALL hold the last written value when EN_writeMem=0.

Reset
REQ-020 With RST=1 at a clock edge, the block SHALL clear wb, wa, rb, ra, BANK_full, ERR_drop, all pipeline valid bits and inflight; the read FSM SHALL go to R_IDLE; in-flight results SHALL be discarded.
REQ-021 During and after reset, EN_writeMem, EN_readMem and VALID_memVal SHALL be 0, both addresses SHALL be 0, and RDY_mult SHALL be 1 on the first cycle with RST=0.
REQ-022 Reset mid-drain SHALL abort the drain, with no further VALID_memVal.

Configuration
REQ-023 With macro MULT_SIGNED_EN defined, operands and results SHALL be two's-complement and extension SHALL sign-extend; without it, all arithmetic SHALL be unsigned and extension SHALL zero-extend.

Verification
REQ-024 Reset, then EN_mult with 3 and 5 in one cycle -> EN_writeMem=1 with addr 0 and val 15 exactly PIPE cycles later.
REQ-025 64 back-to-back requests (AW=6) -> BANK_full=2'b01 after the last write, next write to addr 64, RDY_mult never 0.
REQ-026 Fill both banks with no read -> RDY_mult=0; an extra EN_mult sets ERR_drop=1 and causes no write.
REQ-027 Fill bank 0, pulse EN_blockRead while writing bank 1 -> 64 reads at addr 0..63, VALID_memVal delayed one cycle, BANK_full[0] clears, bank 1 writes uninterrupted.
REQ-028 MULT_SIGNED_EN defined, -2 x 3 -> writeMem_val=32'hFFFFFFFA; undefined, 16'hFFFE x 3 -> 32'h0002FFFA.
